avalon_sampler: RTL and testbench
=================================

Name: avalon_sampler

Overview:
- Parameterised Avalon-ST storage stage: a CAPACITY-deep first-in-first-out buffer of complete stream beats (data, sop, eop, empty).
- Sits between an Avalon-ST source and sink, decoupling them and absorbing short bursts of downstream back-pressure.
- Both sides use the codebase's avalon_st_if interface; data width follows that interface's DATA_WIDTH_IN_BYTES.

Parameters:
- CAPACITY, default 2: number of beats the block can hold; legal range 1 and up.
- No width parameter on the block. Beat width is taken from the connected interfaces (8*DATA_WIDTH_IN_BYTES data bits). Both interfaces must carry the same DATA_WIDTH_IN_BYTES.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- msg_in  avalon_st_if sink  –  inbound stream. The block reads data, vld, sop, eop and empty, and drives rdy.
- msg_out  avalon_st_if source  –  outbound stream. The block drives data, vld, sop, eop and empty, and reads rdy.
- avalon_st_if fields (parameter DATA_WIDTH_IN_BYTES, default 1):
  - data: 8*DATA_WIDTH_IN_BYTES bits.
  - vld, rdy, sop, eop: 1 bit each.
  - empty: max(1, clog2(DATA_WIDTH_IN_BYTES)) bits.

Behaviour:
- Occupancy count cnt runs 0..CAPACITY. Read pointer and write pointer each run 0..CAPACITY-1 and wrap to 0 after CAPACITY-1 (CAPACITY need not be a power of 2).
- Reset (rst_n=0, asynchronous): cnt=0, both pointers 0. Outputs: msg_out.vld=0, msg_in.rdy=1 (after release). msg_out.data/sop/eop/empty=0. Storage contents need not be reset.
- msg_in.rdy = (cnt < CAPACITY). It is registered or combinational from cnt only, never from msg_out.rdy, so there is no combinational in-to-out path.
- Push: msg_in.vld && msg_in.rdy at a rising edge. The whole beat (data, sop, eop, empty) is written at the write pointer, which then advances.
- Beats presented while msg_in.rdy=0 are not captured. Honouring back-pressure is the upstream's responsibility. No error flag.
- msg_out.vld = (cnt != 0). msg_out.data/sop/eop/empty show the beat at the read pointer (oldest entry).
- When msg_out.vld=0, output fields hold the last value; verification must not check them.
- Pop: msg_out.vld && msg_out.rdy at a rising edge. The read pointer advances.
- Latency: a beat pushed at edge N is visible on msg_out with vld=1 after edge N (first-word fall-through from registers). Minimum one cycle; no bypass.
- Simultaneous push and pop: cnt is unchanged. Allowed whenever cnt is between 1 and CAPACITY-1.
- When full, msg_in.rdy=0, so no push occurs even if a pop happens that cycle. rdy rises on the cycle after the pop.
- When empty, no pop can occur (vld=0).
- Throughput: one beat per cycle when msg_out.rdy is held at 1.
- Order is strictly preserved. sop/eop/empty travel with their data beat unchanged; the block does not interpret packet framing.
- Reset mid-operation discards all stored beats immediately: msg_out.vld drops asynchronously.

Decomposition:
- Package avalon_sampler_pkg: function/constant for the empty-field width (max(1, clog2(bytes))), and a localparam helper for pointer width clog2(CAPACITY) with a minimum of 1.
- One sub-module: avalon_sampler_fifo, a generic register-based first-in-first-out buffer.
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop handshakes, full, empty.
  - The top packs {sop, eop, empty, data} into one word and maps interface handshakes onto it.

Test Plan:
- Reset: pulse rst_n low for 1 cycle -> msg_out.vld=0 and msg_in.rdy=1 after release.
- Straight-through (CAPACITY=2, 1 byte, msg_out.rdy=1): stream AA, BB, CC, DD with vld=1 -> msg_out shows AA, BB, CC, DD on consecutive cycles, one cycle later; msg_in.rdy stays 1.
- Fill: msg_out.rdy=0, push AA then BB -> cnt=2, msg_in.rdy=0. Present CC -> not captured. Then set msg_out.rdy=1 -> outputs AA then BB, then vld=0.
- Alternating back-pressure: msg_out.rdy toggles every cycle while 11, 22, 33, 44 are offered only when rdy=1 -> all four appear in order, none duplicated or lost.
- Framing: push beats with sop=1 on the first, eop=1 and empty=0 on the last -> identical flags on the same beats at msg_out.
- Reset mid-stream: cnt=1 holding EE, assert rst_n=0 -> msg_out.vld=0 immediately. After release, EE is never output.

Source files
------------

// File: rtl/avalon_sampler_pkg.sv
// Shared sizing helpers for the Avalon-ST sampler and its stream interface.
package avalon_sampler_pkg;

  // Width of the Avalon-ST empty field: enough bits to count unused bytes,
  // never narrower than one bit so a one-byte bus still carries the field.
  function automatic int empty_width(input int bytes);
    return (bytes <= 1) ? 1 : $clog2(bytes);
  endfunction

  // Width of a pointer that indexes depth entries, at least one bit so a
  // single-entry buffer still has a legal (constant-zero) pointer.
  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage : avalon_sampler_pkg

// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle. Modports are named from the point of view of the
// block that connects to them: a sink reads the beat and drives rdy, a
// source drives the beat and reads rdy.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 1
);
  import avalon_sampler_pkg::*;

  localparam int EMPTY_W = empty_width(DATA_WIDTH_IN_BYTES);

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             vld;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;

  modport sink (
    input  data, vld, sop, eop, empty,
    output rdy
  );

  modport source (
    output data, vld, sop, eop, empty,
    input  rdy
  );

endinterface : avalon_st_if

// File: rtl/avalon_sampler_fifo.sv
// Generic register-based first-in-first-out buffer with first-word
// fall-through: the oldest entry is always presented on pop_data_o.
module avalon_sampler_fifo
  import avalon_sampler_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld_i,
  output logic             push_rdy_o,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             pop_vld_o,
  input  logic             pop_rdy_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_fire;
  logic             pop_fire;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Status comes only from the occupancy count, so ready never depends on
  // the downstream handshake.
  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign push_rdy_o = !full_o;
  assign pop_vld_o  = !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign push_fire = push_vld_i && !full_o;
  assign pop_fire  = pop_rdy_i && !empty_o;

  // Next-state for pointers and occupancy from the two handshakes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_fire) wr_ptr_d = inc_ptr(wr_ptr_q);
    if (pop_fire)  rd_ptr_d = inc_ptr(rd_ptr_q);
    unique case ({push_fire, pop_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the buffer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; cleared on reset so the idle output word reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_fire) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule : avalon_sampler_fifo

// File: rtl/avalon_sampler.sv
// Avalon-ST storage stage: buffers up to CAPACITY complete beats between a
// stream source and sink. Framing fields ride along with the data untouched.
module avalon_sampler
  import avalon_sampler_pkg::*;
#(
  parameter int CAPACITY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  avalon_st_if.sink   msg_in,
  avalon_st_if.source msg_out
);

  // Beat geometry comes from the connected interfaces; both sides are
  // expected to carry the same byte width.
  localparam int DW   = $bits(msg_in.data);
  localparam int EW   = $bits(msg_in.empty);
  localparam int WORD = DW + EW + 2;

  logic [WORD-1:0] push_word;
  logic [WORD-1:0] pop_word;
  logic            push_rdy;
  logic            pop_vld;
  logic            fifo_full;
  logic            fifo_empty;

  // Word layout, MSB first: sop, eop, empty, data.
  assign push_word = {msg_in.sop, msg_in.eop, msg_in.empty, msg_in.data};

  avalon_sampler_fifo #(
    .WIDTH (WORD),
    .DEPTH (CAPACITY)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_vld_i  (msg_in.vld),
    .push_rdy_o  (push_rdy),
    .push_data_i (push_word),
    .pop_vld_o   (pop_vld),
    .pop_rdy_i   (msg_out.rdy),
    .pop_data_o  (pop_word),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign msg_in.rdy    = push_rdy && !fifo_full;
  assign msg_out.vld   = pop_vld && !fifo_empty;
  assign msg_out.data  = pop_word[DW-1:0];
  assign msg_out.empty = pop_word[DW +: EW];
  assign msg_out.eop   = pop_word[DW+EW];
  assign msg_out.sop   = pop_word[DW+EW+1];

endmodule : avalon_sampler

// File: tb/tb_avalon_sampler.sv
// Self-checking bench for avalon_sampler (CAPACITY=2, one-byte beats).
// A queue model tracks the stored beats; a negedge process compares the DUT
// against it every cycle, and directed scenarios add literal expectations.
module tb_avalon_sampler;

  localparam int CAP = 2;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [0:0] empty;
    logic [7:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(1)) in_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(1)) out_if ();

  avalon_sampler #(.CAPACITY(CAP)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .msg_in  (in_if),
    .msg_out (out_if)
  );

  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  beat_t mq[$];
  beat_t out_log[$];
  bit    m_push, m_pop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of at most CAP beats, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      m_push = in_if.vld && (mq.size() < CAP);
      m_pop  = out_if.rdy && (mq.size() != 0);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back({in_if.sop, in_if.eop, in_if.empty, in_if.data});
    end
  end

  // Record every beat the DUT actually hands downstream.
  always @(posedge clk) begin
    if (rst_n && out_if.vld && out_if.rdy)
      out_log.push_back({out_if.sop, out_if.eop, out_if.empty, out_if.data});
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_vld", 32'(out_if.vld), 32'd0);
    end else begin
      chk("in_rdy", 32'(in_if.rdy), 32'(mq.size() < CAP));
      chk("out_vld", 32'(out_if.vld), 32'(mq.size() != 0));
      if (mq.size() != 0)
        chk("out_beat", 32'({out_if.sop, out_if.eop, out_if.empty, out_if.data}), 32'(mq[0]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic e,
                       input logic em);
    in_if.vld   = v;
    in_if.data  = d;
    in_if.sop   = s;
    in_if.eop   = e;
    in_if.empty = em;
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [10:0] exp);
    if (idx < out_log.size()) chk(nm, 32'(out_log[idx]), 32'(exp));
    else chk({nm, "_missing"}, 32'(out_log.size()), 32'(idx + 1));
  endtask

  logic [7:0] seq4 [4];
  int         sent;

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    out_if.rdy = 1'b0;

    // Reset state
    cyc();
    chk("rst_data", 32'(out_if.data), 32'd0);
    chk("rst_sop_eop", 32'({out_if.sop, out_if.eop, out_if.empty}), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_rdy", 32'(in_if.rdy), 32'd1);
    chk("post_rst_vld", 32'(out_if.vld), 32'd0);

    // Straight-through at full rate
    out_if.rdy = 1'b1;
    out_log.delete();
    seq4 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq4[i], 1'b0, 1'b0, 1'b0);
      cyc();
      chk("thru_in_rdy", 32'(in_if.rdy), 32'd1);
      chk("thru_out_data", 32'(out_if.data), 32'(seq4[i]));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc();
    chk("thru_count", 32'(out_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_log("thru_order", i, {3'b000, seq4[i]});

    // Fill, overflow attempt, drain
    out_if.rdy = 1'b0;
    out_log.delete();
    drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0); cyc();
    drive(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0); cyc();
    chk("fill_rdy_low", 32'(in_if.rdy), 32'd0);
    chk("fill_head", 32'(out_if.data), 32'hAA);
    drive(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0); cyc();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    out_if.rdy = 1'b1;
    cyc();
    chk("fill_rdy_back", 32'(in_if.rdy), 32'd1);
    repeat (3) cyc();
    chk("fill_count", 32'(out_log.size()), 32'd2);
    chk_log("fill_first", 0, 11'h0AA);
    chk_log("fill_second", 1, 11'h0BB);
    chk("fill_idle_vld", 32'(out_if.vld), 32'd0);

    // Alternating back-pressure
    out_log.delete();
    seq4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    sent = 0;
    for (int c = 0; c < 40 && !(sent == 4 && !out_if.vld); c++) begin
      out_if.rdy = c[0];
      if (sent < 4 && in_if.rdy) begin
        drive(1'b1, seq4[sent], 1'b0, 1'b0, 1'b0);
        sent++;
      end else begin
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      end
      cyc();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    out_if.rdy = 1'b1;
    repeat (3) cyc();
    chk("alt_count", 32'(out_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_log("alt_order", i, {3'b000, seq4[i]});

    // Framing flags travel with their beats
    out_log.delete();
    drive(1'b1, 8'h01, 1'b1, 1'b0, 1'b1); cyc();
    drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b0); cyc();
    drive(1'b1, 8'h03, 1'b0, 1'b1, 1'b0); cyc();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc();
    chk_log("frame_sop", 0, {1'b1, 1'b0, 1'b1, 8'h01});
    chk_log("frame_mid", 1, {1'b0, 1'b0, 1'b0, 8'h02});
    chk_log("frame_eop", 2, {1'b0, 1'b1, 1'b0, 8'h03});

    // Reset mid-stream discards a held beat
    out_if.rdy = 1'b0;
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0); cyc();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("hold_vld", 32'(out_if.vld), 32'd1);
    chk("hold_data", 32'(out_if.data), 32'hEE);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", 32'(out_if.vld), 32'd0);
    chk("async_rst_rdy", 32'(in_if.rdy), 32'd1);
    cyc();
    rst_n = 1'b1;
    out_if.rdy = 1'b1;
    out_log.delete();
    repeat (5) cyc();
    chk("rst_discard", 32'(out_log.size()), 32'd0);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      out_if.rdy = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    out_if.rdy = 1'b1;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_avalon_sampler
